// File: rtl/spi_frame_tx.sv
// SPI mode-0 initiator for the 88-bit command frame: 8-bit opcode then 80-bit payload, MSB first.
// spi_clk, cs and spi_mosi are divided down from clk_sys; every output comes straight from a flop.
module spi_frame_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic        clk_sys,
    input  logic        rstb,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [79:0] data_packed,
    output logic        ready,
    output logic        done,
    output logic        cs,
    output logic        spi_clk,
    output logic        spi_mosi
);

    localparam int MAX_CNT = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int DW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(CS_IDLE - 1);
    localparam logic [6:0]    BIT_LAST = 7'd87;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [87:0]   sh_q, sh_d;
    logic [6:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;

    // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
    always_ff @(posedge clk_sys or negedge rstb) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d      = {opcode, data_packed};
                    cs_d      = 1'b0;
                    mosi_d    = opcode[7];
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    ready_d   = 1'b0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            S_HIGH: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        // Next bit goes out on the same edge as the spi_clk fall.
                        sh_d      = {sh_q[86:0], 1'b0};
                        mosi_d    = sh_q[86];
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        state_d   = S_LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            S_HOLD: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    cs_d      = 1'b1;
                    state_d   = S_GAP;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            S_GAP: begin
                // cs stays high long enough for the receiver's cs synchronizer to see the rise.
                if (div_cnt_q == GAP_LAST) begin
                    div_cnt_d = '0;
                    ready_d   = 1'b1;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign cs       = cs_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: frames are rebuilt from the SPI pins and compared
// against the frames handed to the block, together with the frame timing and handshake rules.
module tb_spi_frame_tx;

    localparam int CLK_DIV    = 4;
    localparam int CS_IDLE    = 4;
    localparam int FRAME_LAT  = 176 * CLK_DIV + CLK_DIV + CS_IDLE;
    localparam int CS_LOW_LEN = 177 * CLK_DIV;
    localparam int FAST_LAT   = 176 + 1 + CS_IDLE;
    localparam int BOUND      = 2000;

    logic        clk_sys = 1'b0;
    logic        rstb    = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  opcode  = '0;
    logic [79:0] data_packed = '0;
    logic        ready, done, cs, spi_clk, spi_mosi;

    logic        start_f = 1'b0;
    logic [7:0]  opcode_f = '0;
    logic [79:0] data_f = '0;
    logic        ready_f, done_f, cs_f, sclk_f, mosi_f;

    spi_frame_tx #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) u_dut (
        .clk_sys(clk_sys), .rstb(rstb), .start(start), .opcode(opcode),
        .data_packed(data_packed), .ready(ready), .done(done), .cs(cs),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi)
    );

    spi_frame_tx #(.CLK_DIV(1), .CS_IDLE(CS_IDLE)) u_dut_fast (
        .clk_sys(clk_sys), .rstb(rstb), .start(start_f), .opcode(opcode_f),
        .data_packed(data_f), .ready(ready_f), .done(done_f), .cs(cs_f),
        .spi_clk(sclk_f), .spi_mosi(mosi_f)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the frames offered at accept, in order.
    logic [87:0] exp_q[$];

    // Pin monitor: rebuilds frames from the SPI wires and records timing.
    logic [87:0] rx_q[$];
    int          rx_n_q[$];
    logic [87:0] acc;
    int          nbits = 0;
    int          cs_fall_cyc = 0, cs_rise_cyc = 0, cs_low_len = 0, cs_hi_len = 0;
    int          done_cnt = 0;
    logic        mosi_at_rise = 1'b0;
    logic        sclk_cs_high = 1'b0, mosi_unstable = 1'b0, ready_in_frame = 1'b0, done_wide = 1'b0;

    initial begin
        logic prev_sclk, prev_cs, prev_done;
        prev_sclk = 1'b0;
        prev_cs   = 1'b1;
        prev_done = 1'b0;
        acc       = '0;
        forever begin
            @(negedge clk_sys);
            if (spi_clk && !prev_sclk) begin
                if (cs) sclk_cs_high = 1'b1;
                acc          = {acc[86:0], spi_mosi};
                nbits++;
                mosi_at_rise = spi_mosi;
            end else if (spi_clk && spi_mosi !== mosi_at_rise) begin
                mosi_unstable = 1'b1;
            end
            if (!cs && ready) ready_in_frame = 1'b1;
            if (!cs && prev_cs) begin
                cs_hi_len   = cyc - cs_rise_cyc;
                cs_fall_cyc = cyc;
                nbits       = 0;
                acc         = '0;
            end
            if (cs && !prev_cs) begin
                cs_rise_cyc = cyc;
                cs_low_len  = cyc - cs_fall_cyc;
                rx_q.push_back(acc);
                rx_n_q.push_back(nbits);
            end
            if (done) begin
                if (!prev_done) done_cnt++;
                else done_wide = 1'b1;
            end
            prev_sclk = spi_clk;
            prev_cs   = cs;
            prev_done = done;
        end
    end

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic clear_flags();
        sclk_cs_high   = 1'b0;
        mosi_unstable  = 1'b0;
        ready_in_frame = 1'b0;
        done_wide      = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk_sys);
        while (!ready && n < BOUND) begin
            @(negedge clk_sys);
            n++;
        end
        check("ready_timeout", ready, 1'b1);
    endtask

    task automatic drive_frame(input logic [7:0] op, input logic [79:0] d, output int acc_cyc);
        wait_ready();
        clear_flags();
        start       = 1'b1;
        opcode      = op;
        data_packed = d;
        exp_q.push_back({op, d});
        @(negedge clk_sys);
        start   = 1'b0;
        acc_cyc = cyc;
        check("accept_cs", cs, 1'b0);
    endtask

    task automatic wait_done(output int done_cyc);
        int n;
        n = 0;
        while (!done && n < BOUND) begin
            @(negedge clk_sys);
            n++;
        end
        check("done_timeout", done, 1'b1);
        done_cyc = cyc;
    endtask

    task automatic check_rx(input string tag);
        logic [87:0] got, exp;
        int          nb;
        if (rx_q.size() == 0 || exp_q.size() == 0) begin
            check({tag, "_rx_present"}, 88'(rx_q.size()), 88'(exp_q.size() == 0 ? 0 : 1));
            return;
        end
        got = rx_q.pop_front();
        nb  = rx_n_q.pop_front();
        exp = exp_q.pop_front();
        check({tag, "_data"}, got, exp);
        check({tag, "_nbits"}, 88'(nb), 88'd88);
    endtask

    task automatic finish_frame(input string tag, input int acc_cyc);
        int dc;
        wait_done(dc);
        check({tag, "_latency"}, 88'(dc - acc_cyc), 88'(FRAME_LAT));
        @(negedge clk_sys);
        check({tag, "_done_width"}, 88'(done), 88'd0);
        check({tag, "_cs_low"}, 88'(cs_low_len), 88'(CS_LOW_LEN));
        check_rx(tag);
        check({tag, "_flags"}, {84'd0, sclk_cs_high, mosi_unstable, ready_in_frame, done_wide}, 88'd0);
    endtask

    task automatic fast_frame(input logic [7:0] op, input logic [79:0] d);
        int          a, last_rise, nb, lat;
        logic        prev_s, prev_m, bad_period, unstable;
        logic [87:0] rebuilt;
        @(negedge clk_sys);
        start_f  = 1'b1;
        opcode_f = op;
        data_f   = d;
        @(negedge clk_sys);
        start_f    = 1'b0;
        a          = cyc;
        last_rise  = -1;
        nb         = 0;
        lat        = -1;
        rebuilt    = '0;
        bad_period = 1'b0;
        unstable   = 1'b0;
        prev_s     = sclk_f;
        prev_m     = mosi_f;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_sys);
            if (sclk_f && !prev_s) begin
                if (last_rise >= 0 && cyc - last_rise != 2) bad_period = 1'b1;
                if (mosi_f !== prev_m) unstable = 1'b1;
                last_rise = cyc;
                rebuilt   = {rebuilt[86:0], mosi_f};
                nb++;
            end
            prev_s = sclk_f;
            prev_m = mosi_f;
            if (done_f) begin
                lat = cyc - a;
                break;
            end
        end
        check("fast_data", rebuilt, {op, d});
        check("fast_nbits", 88'(nb), 88'd88);
        check("fast_latency", 88'(lat), 88'(FAST_LAT));
        check("fast_period", 88'(bad_period), 88'd0);
        check("fast_mosi_stable", 88'(unstable), 88'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, a2, d1, dc0;
        logic [79:0] d;

        repeat (3) @(negedge clk_sys);
        check("rst_outputs", {83'd0, cs, spi_clk, spi_mosi, ready, done}, {83'd0, 5'b10010});
        rstb = 1'b1;

        // Directed frame at default timing.
        drive_frame(8'hA5, 80'h0123456789ABCDEF0011, a);
        finish_frame("t1", a);

        // start held high across two frames: second accepted in the done cycle.
        wait_ready();
        clear_flags();
        start       = 1'b1;
        opcode      = 8'h3C;
        data_packed = '1;
        exp_q.push_back({8'h3C, 80'hFFFF_FFFF_FFFF_FFFF_FFFF});
        @(negedge clk_sys);
        a = cyc;
        check("t2_accept1", cs, 1'b0);
        opcode      = 8'hC3;
        data_packed = '0;
        exp_q.push_back({8'hC3, 80'h0});
        wait_done(d1);
        check("t2_latency1", 88'(d1 - a), 88'(FRAME_LAT));
        @(negedge clk_sys);
        a2    = cyc;
        start = 1'b0;
        check("t2_accept2", cs, 1'b0);
        check("t2_accept_in_done", 88'(a2 - d1), 88'd1);
        check_rx("t2_f1");
        check("t2_cs_gap", 88'(cs_hi_len), 88'(CS_IDLE + 1));
        finish_frame("t2_f2", a2);

        // Busy ignore: start and inputs toggled mid-frame have no effect.
        drive_frame(8'h96, 80'hDEAD_BEEF_CAFE_F00D_1234, a);
        for (int n = 0; n < BOUND && nbits < 10; n++) @(negedge clk_sys);
        start = 1'b1; opcode = 8'h00; data_packed = '1;
        @(negedge clk_sys);
        start = 1'b0;
        for (int n = 0; n < BOUND && nbits < 60; n++) @(negedge clk_sys);
        start = 1'b1; opcode = 8'hFF; data_packed = '0;
        @(negedge clk_sys);
        start = 1'b0;
        finish_frame("t3", a);
        dc0 = done_cnt;
        repeat (FRAME_LAT + 50) @(negedge clk_sys);
        check("t3_no_extra_frame", 88'(rx_q.size()), 88'd0);
        check("t3_no_extra_done", 88'(done_cnt), 88'(dc0));
        check("t3_idle_pins", {85'd0, cs, spi_clk, ready}, {85'd0, 3'b101});

        // Reset mid-frame.
        drive_frame(8'h77, rand80(), a);
        for (int n = 0; n < BOUND && nbits < 40; n++) @(negedge clk_sys);
        dc0 = done_cnt;
        #2 rstb = 1'b0;
        #1 check("t4_async_reset", {84'd0, cs, spi_clk, ready, done}, {84'd0, 4'b1010});
        repeat (3) @(negedge clk_sys);
        rstb = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("t4_no_done", 88'(done_cnt), 88'(dc0));
        rx_q.delete();
        rx_n_q.delete();
        exp_q.delete();
        d = rand80();
        d[7:0] = 8'hFF;
        drive_frame(8'h5A, d, a);
        finish_frame("t4_after", a);

        // Randomized frames.
        for (int i = 0; i < 4; i++) begin
            drive_frame(8'($urandom), rand80(), a);
            finish_frame($sformatf("rand%0d", i), a);
        end

        // Fastest divider.
        fast_frame(8'hA5, 80'h0123456789ABCDEF0011);
        fast_frame(8'($urandom), rand80());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
